// File: rtl/mmp_iddmm_pkg.sv
// rtl/mmp_iddmm_pkg.sv - shared state encoding for the IDDMM word add/sub block
package mmp_iddmm_pkg;

  // Sequencer states, kept as plain constants so older blocks can share them
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mmp_iddmm_wadd_cell.sv
// rtl/mmp_iddmm_wadd_cell.sv - combinational WD-bit add with carry-in and optional B inversion
module mmp_iddmm_wadd_cell #(
  parameter int WD = 256
) (
  input  logic [WD-1:0] a,
  input  logic [WD-1:0] b,
  input  logic          inv_b,
  input  logic          cin,
  output logic [WD-1:0] sum,
  output logic          cout
);

  logic [WD-1:0] b_eff;

  // Subtraction is A + ~B + 1; the +1 arrives through cin on the first word
  assign b_eff = inv_b ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WD{1'b0}}, cin};

endmodule

// File: rtl/mmp_iddmm_waddsub.sv
// rtl/mmp_iddmm_waddsub.sv - K-word multi-precision add/subtract, one word per valid cycle
module mmp_iddmm_waddsub
  import mmp_iddmm_pkg::*;
#(
  parameter int WD = 256,
  parameter int K  = 4
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_start,
  input  logic          i_sub,
  input  logic          i_valid,
  input  logic [WD-1:0] i_a,
  input  logic [WD-1:0] i_b,
  output logic          o_busy,
  output logic          o_valid,
  output logic [WD-1:0] o_s,
  output logic          o_last,
  output logic          o_done,
  output logic          o_cout
);

  localparam int              CW   = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0]   LAST = CW'(K - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          sub_q;
  logic [WD-1:0] sum;
  logic          cout;
  logic          accept;
  logic          last_word;

  // A word is only consumed while running; IDLE and DONE drop i_valid on the floor
  assign accept    = (state == ST_RUN) && i_valid;
  assign last_word = accept && (cnt == LAST);
  assign o_busy    = (state != ST_IDLE);

  mmp_iddmm_wadd_cell #(.WD(WD)) u_cell (
    .a     (i_a),
    .b     (i_b),
    .inv_b (sub_q),
    .cin   (carry),
    .sum   (sum),
    .cout  (cout)
  );

  // Sequencer: state, word counter, inter-word carry and latched mode
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= ST_IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      sub_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state <= ST_RUN;
            sub_q <= i_sub;
            cnt   <= '0;
            carry <= i_sub;
          end
        end
        ST_RUN: begin
          if (accept) begin
            carry <= cout;
            cnt   <= cnt + 1'b1;
            if (last_word) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output register: the single pipeline stage between operands and o_s
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_s     <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_done  <= 1'b0;
      o_cout  <= 1'b0;
    end else begin
      o_valid <= accept;
      o_last  <= last_word;
      o_done  <= (state == ST_DONE);
      if (accept) begin
        o_s <= sum;
      end
      // Carry-out of A + ~B + 1 is "no borrow", so subtraction reports its inverse
      if (state == ST_DONE) begin
        o_cout <= sub_q ? ~carry : carry;
      end
    end
  end

endmodule

// File: doc/mmp_iddmm_waddsub.md
MMP_IDDMM_WADDSUB -- requirements
Module: mmp_iddmm_waddsub

Interface
REQ-001 SHALL have parameter WD, default 256: operand word width in bits.
REQ-002 SHALL have parameter K, default 4: words per multi-precision operand, K>=1.
REQ-003 SHALL have port i_clk  input  1  clock, rising-edge active.
REQ-004 SHALL have port i_rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_start  input  1  single-cycle request to begin one K-word operation.
REQ-006 SHALL have port i_sub  input  1  mode, sampled with i_start: 0 = A+B, 1 = A-B.
REQ-007 SHALL have port i_valid  input  1  i_a/i_b carry one operand word this cycle, least-significant word first.
REQ-008 SHALL have port i_a  input  WD  operand A word, typically the delay-aligned stream from the upstream shift stage.
REQ-009 SHALL have port i_b  input  WD  operand B word.
REQ-010 SHALL have port o_busy  output  1  high while state is RUN or DONE.
REQ-011 SHALL have port o_valid  output  1  o_s holds a result word.
REQ-012 SHALL have port o_s  output  WD  result word.
REQ-013 SHALL have port o_last  output  1  marks the word K-1 result, coincident with o_valid.
REQ-014 SHALL have port o_done  output  1  single-cycle completion pulse.
REQ-015 SHALL have port o_cout  output  1  final carry (add) or borrow (sub), valid with o_done and held until the next i_start is accepted.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and DONE.
REQ-017 SHALL go IDLE->RUN when i_start=1 in IDLE, latching i_sub, clearing the word counter, and setting the carry register to i_sub.
REQ-018 SHALL ignore i_valid in IDLE, including in the i_start cycle.
REQ-019 SHALL compute {c,s} = i_a + (sub ? ~i_b : i_b) + carry in RUN on each i_valid=1 cycle, register s to o_s and c to carry, and increment the counter.
REQ-020 SHALL assert o_valid exactly one cycle after each accepted word (1-cycle latency), low otherwise.
REQ-021 SHALL tolerate arbitrary i_valid gaps in RUN: carry and counter hold, and o_valid stays low.
REQ-022 SHALL, on accepting word K-1, assert o_last with that o_valid and go RUN->DONE.
REQ-023 SHALL pulse o_done for one cycle in DONE, set o_cout = carry (add) or ~carry (sub), then go DONE->IDLE.
REQ-024 SHALL ignore i_start in RUN and DONE, with no state, counter or carry change.
REQ-025 SHALL ignore i_valid in DONE.
REQ-026 SHALL, for K=1, accept one word and go RUN->DONE, with o_last set on that word.
REQ-027 SHALL wrap all arithmetic modulo 2^WD per word; the counter width is max(1,clog2(K)).

Reset
REQ-028 SHALL, on i_rstn low at any time including mid-operation, force state IDLE, counter 0, carry 0, o_s 0, o_valid 0, o_last 0, o_done 0, o_cout 0 and o_busy 0.
REQ-029 SHALL, after reset deassertion, accept i_start on the first rising edge.

Structure
REQ-030 SHALL take its state encoding from a shared package mmp_iddmm_pkg; WD and K remain module parameters.
REQ-031 SHALL use one natural sub-module, mmp_iddmm_wadd_cell: a combinational WD-bit add with carry-in, optional B inversion, and carry-out.
REQ-032 SHALL not exceed one register stage between i_a/i_b and o_s.

Verification (WD=8, K=4)
REQ-033 SHALL cover add with A={FF,FF,FF,FF}, B={01,00,00,00} -> o_s 00,00,00,00, o_last on the 4th word, o_cout=1, o_done 1 cycle after the 4th o_valid.
REQ-034 SHALL cover sub with A={00,00,00,00}, B={01,00,00,00} -> o_s FF,FF,FF,FF, o_cout=1 (borrow); A={05,..}, B={03,..} with upper words 0 -> o_s 02,00,00,00, o_cout=0.
REQ-035 SHALL cover the REQ-033 add with 2-cycle i_valid gaps between words -> identical o_s sequence, o_valid count exactly 4.
REQ-036 SHALL cover i_start pulsed on the 2nd word of a RUN, plus i_valid asserted in IDLE -> both ignored, result unchanged.
REQ-037 SHALL cover i_rstn asserted after word 2 -> all outputs 0 immediately; a new add of 01+01 (upper words 0) -> o_s 02,00,00,00, o_cout=0.
REQ-038 SHALL cover the K=1 configuration with 80+80 -> o_s 00, o_last=1, o_cout=1.
